credit_link_tx: RTL and testbench

Credit-based link transmitter for the master-to-slave request path. It buffers flits written by the master core and launches them onto the inter-die request bus only while it holds credits. Each credit stands for one free slot in the far-end receive FIFO. Credits are replenished by single-cycle return pulses from the receiver, so this block is the sending counterpart of the receive FIFO and its credit counter.

---
 rtl/credit_link_pkg.sv | 21 ++
 rtl/credit_tx_fifo.sv | 60 ++++++
 rtl/credit_link_tx.sv | 136 +++++++++++++
 tb/tb_credit_link_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_link_pkg.sv
// Shared types and default sizing for the credit-based link transmitter.
package credit_link_pkg;

  localparam int unsigned DATA_WIDTH_DEF      = 40;
  localparam int unsigned FIFO_DEPTH_DEF      = 32;
  localparam int unsigned LOG2_FIFO_DEPTH_DEF = 5;
  localparam int unsigned CREDITS_INIT_DEF    = 32;
  localparam int unsigned STALL_LIMIT_DEF     = 1024;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } tx_state_e;

  // Credit counter width; one extra bit so a full far-end FIFO's worth of credits fits.
  function automatic int unsigned credit_width(input int unsigned log2_depth);
    return log2_depth + 32'd1;
  endfunction

endpackage

// File: rtl/credit_tx_fifo.sv
// Synchronous local flit buffer with wrap-bit pointers and registered full/empty.
module credit_tx_fifo
  import credit_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH      = FIFO_DEPTH_DEF,
  parameter int unsigned LOG2_FIFO_DEPTH = LOG2_FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head_c,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PW = LOG2_FIFO_DEPTH + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr_nxt;
  logic [PW-1:0]         rd_ptr_nxt;
  logic [PW-1:0]         cnt_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // Full is judged before any same-cycle pop, so a write while full is always dropped.
  assign wr_ok      = wr_en & ~full;
  assign rd_ok      = rd_en & ~empty;
  assign wr_ptr_nxt = wr_ptr + PW'(wr_ok);
  assign rd_ptr_nxt = rd_ptr + PW'(rd_ok);
  assign cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
  assign head_c     = mem[rd_ptr[PW-2:0]];

  // Storage array, write port only.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[PW-2:0]] <= wr_data;
    end
  end

  // Pointers and occupancy flags.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      full   <= (cnt_nxt == PW'(FIFO_DEPTH));
      empty  <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/credit_link_tx.sv
// Credit-gated request-path transmitter: buffers master flits, launches them while credits remain.
module credit_link_tx
  import credit_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH      = FIFO_DEPTH_DEF,
  parameter int unsigned LOG2_FIFO_DEPTH = LOG2_FIFO_DEPTH_DEF,
  parameter int unsigned CREDITS_INIT    = CREDITS_INIT_DEF,
  parameter int unsigned STALL_LIMIT     = STALL_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic [DATA_WIDTH-1:0]    i_mc_sreq_inbits,
  input  logic                     i_mc_sreq_wen,
  output logic                     o_mc_sreq_fifo_full,
  output logic                     o_mc_sreq_fifo_empty,
  input  logic                     i_link_up,
  input  logic                     i_credit_return,
  output logic                     o_link_valid,
  output logic [DATA_WIDTH-1:0]    o_link_bits,
  output logic [LOG2_FIFO_DEPTH:0] o_credits,
  output logic                     o_overflow,
  output logic                     o_credit_error,
  output logic                     o_stall_timeout
);

  localparam int unsigned CW = credit_width(LOG2_FIFO_DEPTH);
  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

  tx_state_e             state;
  tx_state_e             state_nxt;
  logic                  send_c;
  logic                  ret_err_c;
  logic                  credits_zero_c;
  logic [CW-1:0]         credits_nxt;
  logic [SW-1:0]         stall_cnt;
  logic [SW-1:0]         stall_cnt_nxt;
  logic [DATA_WIDTH-1:0] fifo_head_c;

  credit_tx_fifo #(
    .DATA_WIDTH      (DATA_WIDTH),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .LOG2_FIFO_DEPTH (LOG2_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .wr_en   (i_mc_sreq_wen),
    .wr_data (i_mc_sreq_inbits),
    .rd_en   (send_c),
    .head_c  (fifo_head_c),
    .full    (o_mc_sreq_fifo_full),
    .empty   (o_mc_sreq_fifo_empty)
  );

  // Launch decision and credit arithmetic; a return at the ceiling without a send is refused.
  assign credits_zero_c = (o_credits == '0);
  assign send_c         = (state == ST_ACTIVE) & ~o_mc_sreq_fifo_empty & ~credits_zero_c;
  assign ret_err_c      = i_credit_return & ~send_c & (o_credits == CW'(CREDITS_INIT));
  assign credits_nxt    = o_credits - CW'(send_c) + CW'(i_credit_return & ~ret_err_c);

  // State register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and stall-counter logic; link loss wins over everything.
  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = '0;
    case (state)
      ST_INIT: begin
        if (i_link_up) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!i_link_up) begin
          state_nxt = ST_INIT;
        end else if (!o_mc_sreq_fifo_empty && credits_zero_c) begin
          state_nxt = ST_STALL;
        end
      end
      ST_STALL: begin
        if (!i_link_up) begin
          state_nxt = ST_INIT;
        end else if (!credits_zero_c) begin
          state_nxt = ST_ACTIVE;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
    if (state == ST_STALL && state_nxt == ST_STALL) begin
      stall_cnt_nxt = (stall_cnt == SW'(STALL_LIMIT)) ? stall_cnt : stall_cnt + SW'(1);
    end
  end

  // Credit and stall counters.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_credits <= CW'(CREDITS_INIT);
      stall_cnt <= '0;
    end else begin
      o_credits <= credits_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  // Output flit register; bits hold their last value between flits.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_link_valid <= 1'b0;
      o_link_bits  <= '0;
    end else begin
      o_link_valid <= send_c;
      if (send_c) begin
        o_link_bits <= fifo_head_c;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow      <= 1'b0;
      o_credit_error  <= 1'b0;
      o_stall_timeout <= 1'b0;
    end else begin
      o_overflow      <= o_overflow | (i_mc_sreq_wen & o_mc_sreq_fifo_full);
      o_credit_error  <= o_credit_error | ret_err_c;
      o_stall_timeout <= o_stall_timeout | (stall_cnt_nxt == SW'(STALL_LIMIT));
    end
  end

endmodule

// File: tb/tb_credit_link_tx.sv
// Bench for credit_link_tx: vector table plus scoreboarded corner-case sequences.
module tb_credit_link_tx;

  localparam int unsigned DW = 40;
  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic [DW-1:0] i_mc_sreq_inbits;
  logic          i_mc_sreq_wen;
  logic          o_mc_sreq_fifo_full;
  logic          o_mc_sreq_fifo_empty;
  logic          i_link_up;
  logic          i_credit_return;
  logic          o_link_valid;
  logic [DW-1:0] o_link_bits;
  logic [CW-1:0] o_credits;
  logic          o_overflow;
  logic          o_credit_error;
  logic          o_stall_timeout;

  always #5 clk = ~clk;

  credit_link_tx dut (
    .clk                  (clk),
    .i_rst_n              (i_rst_n),
    .i_mc_sreq_inbits     (i_mc_sreq_inbits),
    .i_mc_sreq_wen        (i_mc_sreq_wen),
    .o_mc_sreq_fifo_full  (o_mc_sreq_fifo_full),
    .o_mc_sreq_fifo_empty (o_mc_sreq_fifo_empty),
    .i_link_up            (i_link_up),
    .i_credit_return      (i_credit_return),
    .o_link_valid         (o_link_valid),
    .o_link_bits          (o_link_bits),
    .o_credits            (o_credits),
    .o_overflow           (o_overflow),
    .o_credit_error       (o_credit_error),
    .o_stall_timeout      (o_stall_timeout)
  );

  typedef struct {
    logic          wen;
    logic [DW-1:0] data;
    logic          link;
    logic          cr;
    logic          ev;
    logic [DW-1:0] eb;
    logic [CW-1:0] ec;
    logic          ee;
    logic          eerr;
  } vec_t;

  vec_t          tbl [12];
  logic [DW-1:0] sb_q [$];
  int            n_vec  = 0;
  int            n_miss = 0;
  int            n_sent = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock; every launched flit is matched against the scoreboard.
  task automatic tick();
    logic [DW-1:0] exp;
    @(posedge clk);
    #1;
    if (o_link_valid) begin
      n_sent++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected flit: got 0x%0h, want no flit", o_link_bits);
      end else begin
        exp = sb_q.pop_front();
        chk("flit order", 64'(o_link_bits), 64'(exp));
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " valid"},    64'(o_link_valid),         64'(0));
    chk({tag, " bits"},     64'(o_link_bits),          64'(0));
    chk({tag, " credits"},  64'(o_credits),            64'(32));
    chk({tag, " empty"},    64'(o_mc_sreq_fifo_empty), 64'(1));
    chk({tag, " full"},     64'(o_mc_sreq_fifo_full),  64'(0));
    chk({tag, " overflow"}, 64'(o_overflow),           64'(0));
    chk({tag, " crd_err"},  64'(o_credit_error),       64'(0));
    chk({tag, " timeout"},  64'(o_stall_timeout),      64'(0));
  endtask

  initial begin
    logic do5;
    logic did5;

    //        wen   data       link  cr    ev    eb         ec     ee    eerr
    tbl[0]  = '{1'b0, 40'h0,    1'b1, 1'b0, 1'b0, 40'h0,    6'd32, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 40'hA0,   1'b1, 1'b0, 1'b0, 40'h0,    6'd32, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 40'hA1,   1'b1, 1'b0, 1'b1, 40'hA0,   6'd31, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 40'hA2,   1'b1, 1'b0, 1'b1, 40'hA1,   6'd30, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 40'h0,    1'b1, 1'b0, 1'b1, 40'hA2,   6'd29, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 40'h0,    1'b1, 1'b0, 1'b0, 40'hA2,   6'd29, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 40'h0,    1'b1, 1'b1, 1'b0, 40'hA2,   6'd30, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 40'h0,    1'b1, 1'b1, 1'b0, 40'hA2,   6'd31, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 40'h0,    1'b1, 1'b1, 1'b0, 40'hA2,   6'd32, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 40'hB0,   1'b1, 1'b0, 1'b0, 40'hA2,   6'd32, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 40'h0,    1'b1, 1'b1, 1'b1, 40'hB0,   6'd32, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 40'h0,    1'b1, 1'b1, 1'b0, 40'hB0,   6'd32, 1'b1, 1'b1};

    i_rst_n          = 1'b0;
    i_mc_sreq_inbits = '0;
    i_mc_sreq_wen    = 1'b0;
    i_link_up        = 1'b0;
    i_credit_return  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    i_rst_n = 1'b1;
    tick();
    chk_reset("post-por");

    // Basic flow, latency, credit arithmetic and credit-ceiling error.
    for (int i = 0; i < 12; i++) begin
      i_mc_sreq_wen    = tbl[i].wen;
      i_mc_sreq_inbits = tbl[i].data;
      i_link_up        = tbl[i].link;
      i_credit_return  = tbl[i].cr;
      if (tbl[i].wen) sb_q.push_back(tbl[i].data);
      tick();
      chk($sformatf("vec%0d valid", i),   64'(o_link_valid),         64'(tbl[i].ev));
      chk($sformatf("vec%0d bits", i),    64'(o_link_bits),          64'(tbl[i].eb));
      chk($sformatf("vec%0d credits", i), 64'(o_credits),            64'(tbl[i].ec));
      chk($sformatf("vec%0d empty", i),   64'(o_mc_sreq_fifo_empty), 64'(tbl[i].ee));
      chk($sformatf("vec%0d full", i),    64'(o_mc_sreq_fifo_full),  64'(0));
      chk($sformatf("vec%0d crd_err", i), 64'(o_credit_error),       64'(tbl[i].eerr));
    end
    i_mc_sreq_wen   = 1'b0;
    i_credit_return = 1'b0;

    // Exhaust credits under a stream, with one send+return collision at 5 credits.
    n_sent = 0;
    did5   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      i_mc_sreq_wen    = 1'b1;
      i_mc_sreq_inbits = DW'(40'hC00 + i);
      sb_q.push_back(i_mc_sreq_inbits);
      do5             = !did5 && (o_credits == 6'd5);
      i_credit_return = do5;
      tick();
      if (do5) begin
        did5 = 1'b1;
        chk("send+return credits", 64'(o_credits), 64'(5));
        chk("send+return valid", 64'(o_link_valid), 64'(1));
      end
      i_credit_return = 1'b0;
    end
    i_mc_sreq_wen = 1'b0;
    chk("credits reached 5", 64'(did5), 64'(1));
    repeat (5) tick();
    chk("exhaust sent", 64'(n_sent), 64'(33));
    chk("exhaust credits", 64'(o_credits), 64'(0));
    chk("exhaust empty", 64'(o_mc_sreq_fifo_empty), 64'(0));
    chk("exhaust queued", 64'(sb_q.size()), 64'(7));
    repeat (995) tick();
    chk("timeout early", 64'(o_stall_timeout), 64'(0));
    repeat (30) tick();
    chk("timeout set", 64'(o_stall_timeout), 64'(1));

    // Returning credits releases the stalled flits; timeout stays sticky.
    repeat (7) begin
      i_credit_return = 1'b1;
      tick();
    end
    i_credit_return = 1'b0;
    repeat (10) tick();
    chk("drain credits", 64'(o_credits), 64'(0));
    chk("drain empty", 64'(o_mc_sreq_fifo_empty), 64'(1));
    chk("drain scoreboard", 64'(sb_q.size()), 64'(0));
    chk("drain sent", 64'(n_sent), 64'(40));
    chk("timeout sticky", 64'(o_stall_timeout), 64'(1));
    repeat (32) begin
      i_credit_return = 1'b1;
      tick();
    end
    i_credit_return = 1'b0;
    tick();
    chk("refill credits", 64'(o_credits), 64'(32));

    // Link down: fill to full, overflow on the 33rd write, then drain in order.
    i_link_up = 1'b0;
    tick();
    n_sent = 0;
    for (int i = 0; i < 33; i++) begin
      i_mc_sreq_wen    = 1'b1;
      i_mc_sreq_inbits = DW'(40'h100 + i);
      if (i < 32) sb_q.push_back(i_mc_sreq_inbits);
      tick();
      if (i == 30) chk("full at 31", 64'(o_mc_sreq_fifo_full), 64'(0));
      if (i == 31) begin
        chk("full at 32", 64'(o_mc_sreq_fifo_full), 64'(1));
        chk("overflow at 32", 64'(o_overflow), 64'(0));
      end
    end
    i_mc_sreq_wen = 1'b0;
    chk("overflow set", 64'(o_overflow), 64'(1));
    chk("full held", 64'(o_mc_sreq_fifo_full), 64'(1));
    chk("link down sent", 64'(n_sent), 64'(0));
    i_link_up = 1'b1;
    repeat (40) tick();
    chk("ovf sent", 64'(n_sent), 64'(32));
    chk("ovf scoreboard", 64'(sb_q.size()), 64'(0));
    chk("ovf credits", 64'(o_credits), 64'(0));
    chk("ovf empty", 64'(o_mc_sreq_fifo_empty), 64'(1));
    chk("ovf full", 64'(o_mc_sreq_fifo_full), 64'(0));

    // Asynchronous reset in the middle of a burst.
    repeat (10) begin
      i_credit_return = 1'b1;
      tick();
    end
    i_credit_return = 1'b0;
    tick();
    chk("pre-burst credits", 64'(o_credits), 64'(10));
    for (int i = 0; i < 4; i++) begin
      i_mc_sreq_wen    = 1'b1;
      i_mc_sreq_inbits = DW'(40'hE00 + i);
      sb_q.push_back(i_mc_sreq_inbits);
      tick();
    end
    i_mc_sreq_wen = 1'b0;
    chk("mid-burst valid", 64'(o_link_valid), 64'(1));
    i_rst_n = 1'b0;
    #1;
    chk_reset("async");
    sb_q.delete();
    tick();
    tick();
    i_rst_n = 1'b1;
    n_sent  = 0;
    repeat (10) tick();
    chk("post-reset sent", 64'(n_sent), 64'(0));
    chk("post-reset empty", 64'(o_mc_sreq_fifo_empty), 64'(1));
    chk("post-reset credits", 64'(o_credits), 64'(32));
    i_mc_sreq_wen    = 1'b1;
    i_mc_sreq_inbits = 40'hE9;
    sb_q.push_back(i_mc_sreq_inbits);
    tick();
    i_mc_sreq_wen = 1'b0;
    chk("new write lat1 valid", 64'(o_link_valid), 64'(0));
    tick();
    chk("new write lat2 valid", 64'(o_link_valid), 64'(1));
    chk("new write credits", 64'(o_credits), 64'(31));
    chk("new write scoreboard", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
